// File: rtl/hpdmc_ddr16_wrpath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_ddr16_wrpath_pkg
// Description : Shared state encodings and burst constants for the DDR16
//               write datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package hpdmc_ddr16_wrpath_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_PRE  = 3'd2,
      ST_DATA = 3'd3,
      ST_POST = 3'd4
   } wr_state_t;

   localparam int c_beats  = 4;
   localparam int c_wl_min = 2;
   localparam int c_wl_max = 4;

endpackage : hpdmc_ddr16_wrpath_pkg
`default_nettype wire

// File: rtl/hpdmc_ddr16_beatsel.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_ddr16_beatsel
// Description : Combinational beat slicer: picks the D0/D1 DQ and DM halves
//               of one beat out of a BL8 burst, MSB half-beat first.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdmc_ddr16_beatsel #(
   parameter int DW = 16
) (
   input  logic [8*DW-1:0]   i_burst_data,
   input  logic [DW-1:0]     i_burst_mask,
   input  logic [1:0]        i_beat,
   output logic [DW-1:0]     o_dq_d0,
   output logic [DW-1:0]     o_dq_d1,
   output logic [DW/8-1:0]   o_dm_d0,
   output logic [DW/8-1:0]   o_dm_d1
);

   localparam int c_mw = DW / 8;

   int w_dq_top;
   int w_dm_top;

   // Each beat consumes two half-beats; the D0 half sits above the D1 half.
   always_comb begin
      w_dq_top = 8*DW - 1 - 2*DW*int'(i_beat);
      w_dm_top = DW - 1 - 2*c_mw*int'(i_beat);
      o_dq_d0  = i_burst_data[w_dq_top -: DW];
      o_dq_d1  = i_burst_data[w_dq_top - DW -: DW];
      o_dm_d0  = i_burst_mask[w_dm_top -: c_mw];
      o_dm_d1  = i_burst_mask[w_dm_top - c_mw -: c_mw];
   end

endmodule : hpdmc_ddr16_beatsel
`default_nettype wire

// File: rtl/hpdmc_ddr16_wrpath.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_ddr16_wrpath
// Description : DDR16 write burst serializer feeding the DQ/DM/DQS ODDR2
//               cells, with DQS preamble/postamble and one-deep burst queue.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdmc_ddr16_wrpath
   import hpdmc_ddr16_wrpath_pkg::*;
#(
   parameter int DW = 16,
   parameter int WL = 2
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              wr_start,
   input  logic [8*DW-1:0]   wr_data,
   input  logic [DW-1:0]     wr_mask,
   output logic              ready,
   output logic              busy,
   output logic              wr_err,
   output logic [DW-1:0]     dq_d0,
   output logic [DW-1:0]     dq_d1,
   output logic [DW/8-1:0]   dm_d0,
   output logic [DW/8-1:0]   dm_d1,
   output logic              dqs_d0,
   output logic              dqs_d1,
   output logic              dq_oe,
   output logic              dqs_oe
);

   localparam int         c_mw         = DW / 8;
   localparam logic [1:0] c_ready_beat = 2'(c_beats - WL);
   localparam logic [1:0] c_last_beat  = 2'(c_beats - 1);
   localparam logic [1:0] c_wait_init  = 2'((WL > c_wl_min) ? (WL - 3) : 0);

   wr_state_t          r_state;
   logic [1:0]         r_beat;
   logic [1:0]         r_wait_cnt;
   logic [8*DW-1:0]    r_burst_data;
   logic [DW-1:0]      r_burst_mask;
   logic [8*DW-1:0]    r_pend_data;
   logic [DW-1:0]      r_pend_mask;
   logic               r_pend_valid;
   logic               r_wr_err;
   logic [DW-1:0]      r_dq_d0;
   logic [DW-1:0]      r_dq_d1;
   logic [c_mw-1:0]    r_dm_d0;
   logic [c_mw-1:0]    r_dm_d1;
   logic               r_dqs_d0;
   logic               r_dq_oe;
   logic               r_dqs_oe;

   logic               w_ready;
   logic               w_accept;
   logic               w_last;
   logic               w_next_pre;
   logic               w_next_post;
   logic               w_next_data;
   logic [8*DW-1:0]    w_sel_data;
   logic [DW-1:0]      w_sel_mask;
   logic [1:0]         w_sel_beat;
   logic [DW-1:0]      w_dq_d0;
   logic [DW-1:0]      w_dq_d1;
   logic [c_mw-1:0]    w_dm_d0;
   logic [c_mw-1:0]    w_dm_d1;

   assign w_ready  = (r_state == ST_IDLE) ||
                     (r_state == ST_DATA && r_beat == c_ready_beat && !r_pend_valid);
   assign w_accept = wr_start && w_ready;
   assign w_last   = (r_state == ST_DATA) && (r_beat == c_last_beat);

   assign w_next_pre  = (r_state == ST_IDLE && w_accept && WL == c_wl_min) ||
                        (r_state == ST_WAIT && r_wait_cnt == 2'd0);
   assign w_next_post = w_last && !r_pend_valid;
   assign w_next_data = (r_state == ST_PRE) || (r_state == ST_DATA && !w_next_post);

   // Outputs are registered, so the slicer looks one beat ahead: the queued
   // burst takes over right after the last beat of the current one.
   assign w_sel_data = w_last ? r_pend_data : r_burst_data;
   assign w_sel_mask = w_last ? r_pend_mask : r_burst_mask;
   assign w_sel_beat = (r_state == ST_DATA) ? (r_beat + 2'd1) : 2'd0;

   hpdmc_ddr16_beatsel #(
      .DW (DW)
   ) u_beatsel (
      .i_burst_data (w_sel_data),
      .i_burst_mask (w_sel_mask),
      .i_beat       (w_sel_beat),
      .o_dq_d0      (w_dq_d0),
      .o_dq_d1      (w_dq_d1),
      .o_dm_d0      (w_dm_d0),
      .o_dm_d1      (w_dm_d1)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state      <= ST_IDLE;
         r_beat       <= 2'd0;
         r_wait_cnt   <= 2'd0;
         r_burst_data <= '0;
         r_burst_mask <= '0;
         r_pend_data  <= '0;
         r_pend_mask  <= '0;
         r_pend_valid <= 1'b0;
         r_wr_err     <= 1'b0;
         r_dq_d0      <= '0;
         r_dq_d1      <= '0;
         r_dm_d0      <= '0;
         r_dm_d1      <= '0;
         r_dqs_d0     <= 1'b0;
         r_dq_oe      <= 1'b0;
         r_dqs_oe     <= 1'b0;
      end else begin
         if (wr_start && !w_ready)
            r_wr_err <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_burst_data <= wr_data;
                  r_burst_mask <= wr_mask;
                  r_wait_cnt   <= c_wait_init;
                  r_state      <= w_next_pre ? ST_PRE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_wait_cnt == 2'd0)
                  r_state <= ST_PRE;
               else
                  r_wait_cnt <= r_wait_cnt - 2'd1;
            end
            ST_PRE: begin
               r_state <= ST_DATA;
               r_beat  <= 2'd0;
            end
            ST_DATA: begin
               if (w_accept) begin
                  r_pend_data  <= wr_data;
                  r_pend_mask  <= wr_mask;
                  r_pend_valid <= 1'b1;
               end
               r_beat <= r_beat + 2'd1;
               if (w_last) begin
                  if (r_pend_valid) begin
                     r_burst_data <= r_pend_data;
                     r_burst_mask <= r_pend_mask;
                     r_pend_valid <= 1'b0;
                  end else begin
                     r_state <= ST_POST;
                  end
               end
            end
            ST_POST: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase

         r_dq_oe  <= w_next_data;
         r_dqs_oe <= w_next_data || w_next_pre || w_next_post;
         r_dqs_d0 <= w_next_data;
         r_dq_d0  <= w_next_data ? w_dq_d0 : '0;
         r_dq_d1  <= w_next_data ? w_dq_d1 : '0;
         r_dm_d0  <= w_next_data ? w_dm_d0 : '0;
         r_dm_d1  <= w_next_data ? w_dm_d1 : '0;
      end
   end

   assign ready  = w_ready;
   assign busy   = (r_state != ST_IDLE) || r_pend_valid;
   assign wr_err = r_wr_err;
   assign dq_d0  = r_dq_d0;
   assign dq_d1  = r_dq_d1;
   assign dm_d0  = r_dm_d0;
   assign dm_d1  = r_dm_d1;
   assign dqs_d0 = r_dqs_d0;
   assign dqs_d1 = 1'b0;
   assign dq_oe  = r_dq_oe;
   assign dqs_oe = r_dqs_oe;

endmodule : hpdmc_ddr16_wrpath
`default_nettype wire
